// File: rtl/calc_pkg.sv
// Shared constants and instruction-field helpers for the parametrised calculator core.
// Instruction words are packed {op, ra, rb, rc}, each register field RW bits wide.
package calc_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_SEND = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;

    // Helpers take the instruction zero-extended to 32 bits; callers truncate to RW.
    function automatic logic [1:0] inst_op(input logic [31:0] inst, input int rw);
        return 2'((inst >> (3 * rw)) & 32'h3);
    endfunction

    function automatic logic [7:0] inst_ra(input logic [31:0] inst, input int rw);
        return 8'((inst >> (2 * rw)) & ((32'd1 << rw) - 32'd1));
    endfunction

    function automatic logic [7:0] inst_rb(input logic [31:0] inst, input int rw);
        return 8'((inst >> rw) & ((32'd1 << rw) - 32'd1));
    endfunction

    function automatic logic [7:0] inst_rc(input logic [31:0] inst, input int rw);
        return 8'(inst & ((32'd1 << rw) - 32'd1));
    endfunction

endpackage

// File: rtl/calc_tx_fifo.sv
// First-word fall-through FIFO buffering SEND results toward the UART transmit path.
// Push on full and pop on empty are dropped so the pointers can never corrupt.
module calc_tx_fifo #(
    parameter  int DW         = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [FIFO_DEPTH-1:0][DW-1:0] mem;
    logic [AW-1:0]                 wr_ptr, rd_ptr;
    logic                          do_push, do_pop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Depth is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/calc_core_param.sv
// Parametrised nibble calculator core: PUSH/ADD/MULT/SEND on an NREG x DW register file,
// iterative shift-add multiplier, and an output FIFO feeding the transmit stream.
module calc_core_param
    import calc_pkg::*;
#(
    parameter  int DW         = 8,
    parameter  int NREG       = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int RW         = $clog2(NREG),
    localparam int IMW        = 2 * RW,
    localparam int IW         = 2 + 3 * RW,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inst_valid,
    input  logic [IW-1:0] inst_data,
    output logic          inst_ready,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    output logic          retire,
    output logic [IW-1:0] retire_inst,
    output logic          ovf,
    output logic [CW-1:0] fifo_cnt
);

    localparam int SW = $clog2(DW) + 1;

    logic [NREG-1:0][DW-1:0] regs;
    logic [1:0]              state;
    logic [SW-1:0]           step;
    logic [2*DW-1:0]         prod;
    logic [DW-1:0]           mcand;
    logic [IW-1:0]           mul_inst;

    logic [1:0]      op;
    logic [RW-1:0]   ra, rb, rc, mul_ra;
    logic            fifo_full, fifo_empty, accept, push, mul_done;
    logic [DW:0]     add_sum, mul_hi;
    logic [2*DW-1:0] prod_next;

    assign op     = inst_op(32'(inst_data), RW);
    assign ra     = RW'(inst_ra(32'(inst_data), RW));
    assign rb     = RW'(inst_rb(32'(inst_data), RW));
    assign rc     = RW'(inst_rc(32'(inst_data), RW));
    assign mul_ra = RW'(inst_ra(32'(mul_inst), RW));

    assign inst_ready = (state == ST_IDLE) && !fifo_full;
    assign accept     = inst_valid && inst_ready;
    assign push       = accept && (op == OP_SEND);
    assign add_sum    = {1'b0, regs[rb]} + {1'b0, regs[rc]};

    // prod holds {partial sum, unconsumed multiplier bits}; each step shifts right by one.
    assign mul_hi    = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_next = {mul_hi, prod[DW-1:1]};
    assign mul_done  = (state == ST_MUL) && (step == SW'(DW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs        <= '0;
            state       <= ST_IDLE;
            step        <= '0;
            prod        <= '0;
            mcand       <= '0;
            mul_inst    <= '0;
            retire      <= 1'b0;
            retire_inst <= '0;
            ovf         <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op != OP_MULT) begin
                            retire      <= 1'b1;
                            retire_inst <= inst_data;
                        end
                        case (op)
                            OP_PUSH: regs[ra] <= {regs[ra][DW-IMW-1:0], rb, rc};
                            OP_ADD: begin
                                regs[ra] <= add_sum[DW-1:0];
                                if (add_sum[DW]) ovf <= 1'b1;
                            end
                            OP_MULT: begin
                                mcand    <= regs[rb];
                                prod     <= {{DW{1'b0}}, regs[rc]};
                                step     <= '0;
                                mul_inst <= inst_data;
                                state    <= ST_MUL;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    prod <= prod_next;
                    step <= step + SW'(1);
                    if (mul_done) begin
                        regs[mul_ra] <= prod_next[DW-1:0];
                        if (|prod_next[2*DW-1:DW]) ovf <= 1'b1;
                        retire      <= 1'b1;
                        retire_inst <= mul_inst;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    calc_tx_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (regs[ra]),
        .pop       (tx_ready),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_calc_core_param.sv
// Scoreboard bench for calc_core_param: default instance (DW=8, NREG=4) plus a DW=16, NREG=8 instance.
`timescale 1ns/1ps
module tb_calc_core_param;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       inst_valid = 1'b0;
    logic [7:0] inst_data = '0;
    logic       inst_ready, tx_valid, retire, ovf;
    logic [7:0] tx_data, retire_inst;
    logic       tx_ready = 1'b1;
    logic [2:0] fifo_cnt;

    calc_core_param #(.DW(8), .NREG(4), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_ready(inst_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .retire(retire), .retire_inst(retire_inst), .ovf(ovf), .fifo_cnt(fifo_cnt)
    );

    logic        inst_valid1 = 1'b0;
    logic [10:0] inst_data1 = '0;
    logic        inst_ready1, tx_valid1, retire1, ovf1;
    logic [15:0] tx_data1;
    logic [10:0] retire_inst1;
    logic        tx_ready1 = 1'b0;
    logic [2:0]  fifo_cnt1;

    calc_core_param #(.DW(16), .NREG(8), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid1), .inst_data(inst_data1),
        .inst_ready(inst_ready1), .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
        .retire(retire1), .retire_inst(retire_inst1), .ovf(ovf1), .fifo_cnt(fifo_cnt1)
    );

    int total = 0;
    int bad = 0;
    int m[4];
    longint r1[8];
    int retire_cnt = 0;
    int accepted = 0;
    int txq[$];
    logic [7:0] rq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every popped FIFO word and every retire against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (txq.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_extra: got 0x%0h expected no word", tx_data);
            end else chk("tx_data", tx_data, txq.pop_front());
        end
        if (rst_n && retire) begin
            retire_cnt++;
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL retire_extra: got 0x%0h expected no retire", retire_inst);
            end else chk("retire_inst", retire_inst, rq.pop_front());
        end
    end

    task automatic issue(input logic [1:0] op, input int a, input int b, input int c);
        int n;
        int res;
        logic [7:0] d;
        n = 0;
        d = {op, 2'(a), 2'(b), 2'(c)};
        @(negedge clk);
        inst_valid = 1'b1;
        inst_data  = d;
        while (!inst_ready && n < 200) begin @(negedge clk); n++; end
        if (!inst_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
            inst_valid = 1'b0;
            return;
        end
        @(posedge clk);
        case (op)
            OP_PUSH: m[a] = ((m[a] << 4) | (b * 4 + c)) & 255;
            OP_ADD: begin
                res = m[b] + m[c];
                if (res > 255) m[a] = res & 255; else m[a] = res;
            end
            OP_MULT: begin
                res = m[b] * m[c];
                m[a] = res & 255;
            end
            default: txq.push_back(m[a]);
        endcase
        rq.push_back(d);
        accepted++;
        #1 inst_valid = 1'b0;
        if (op == OP_MULT) begin
            n = 0;
            @(negedge clk);
            while (!inst_ready && n < 100) begin n++; @(negedge clk); end
            chk("mul_busy_cycles", n, 8);
        end
    endtask

    task automatic push_nib(input int a, input int nib);
        issue(OP_PUSH, a, nib >> 2, nib & 3);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((txq.size() != 0 || rq.size() != 0) && n < 100) begin @(negedge clk); n++; end
        chk("drain_tx", txq.size(), 0);
        chk("drain_retire", rq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        inst_valid = 1'b0;
        inst_valid1 = 1'b0;
        m = '{default: 0};
        r1 = '{default: 0};
        txq.delete();
        rq.delete();
        retire_cnt = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_retire", retire, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
    endtask

    task automatic issue1(input logic [1:0] op, input int a, input int b, input int c);
        int n;
        longint p;
        n = 0;
        @(negedge clk);
        inst_valid1 = 1'b1;
        inst_data1  = {op, 3'(a), 3'(b), 3'(c)};
        while (!inst_ready1 && n < 200) begin @(negedge clk); n++; end
        if (!inst_ready1) begin
            total++; bad++;
            $display("FAIL accept1_timeout: got no accept expected accept within 200 cycles");
            inst_valid1 = 1'b0;
            return;
        end
        @(posedge clk);
        case (op)
            OP_PUSH: r1[a] = ((r1[a] << 6) | (b * 8 + c)) & 64'hFFFF;
            OP_ADD:  r1[a] = (r1[b] + r1[c]) & 64'hFFFF;
            OP_MULT: begin p = r1[b] * r1[c]; r1[a] = p & 64'hFFFF; end
            default: ;
        endcase
        #1 inst_valid1 = 1'b0;
        if (op == OP_MULT) begin
            n = 0;
            @(negedge clk);
            while (!inst_ready1 && n < 100) begin n++; @(negedge clk); end
            chk("mul16_busy_cycles", n, 16);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        logic [10:0] last1;

        do_reset();

        // Nibble shift-in
        push_nib(0, 4);
        push_nib(0, 0);
        repeat (2) @(negedge clk);
        chk("push_retires", retire_cnt, 2);

        // MULT / ADD / SEND chain
        push_nib(1, 3);
        issue(OP_MULT, 2, 0, 1);
        issue(OP_ADD, 3, 2, 0);
        @(negedge clk);
        chk("add_ovf", ovf, 1);
        for (int i = 0; i < 4; i++) issue(OP_SEND, i, 0, 0);
        drain();

        // Random instruction mix with tx_ready toggling, checked only through SEND results
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            issue(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) issue(OP_SEND, i, 0, 0);
        drain();

        // Fibonacci stream
        do_reset();
        push_nib(0, 0);
        push_nib(1, 1);
        for (int i = 0; i < 10; i++) begin
            issue(OP_ADD, 2, 0, 1);
            issue(OP_SEND, 0, 0, 0);
            issue(OP_ADD, 0, 1, 3);
            issue(OP_ADD, 1, 2, 3);
        end
        drain();
        chk("fib_ovf", ovf, 0);

        // Backpressure with a full FIFO
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_nib(i, i + 1);
        for (int i = 0; i < 4; i++) issue(OP_SEND, i, 0, 0);
        @(negedge clk);
        chk("full_cnt", fifo_cnt, 4);
        chk("full_ready", inst_ready, 0);
        n0 = accepted;
        fork
            issue(OP_SEND, 0, 0, 0);
        join_none
        repeat (3) @(negedge clk);
        chk("stall_hold", accepted, n0);
        chk("stall_cnt", fifo_cnt, 4);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_release", accepted, n0 + 1);
        chk("refill_cnt", fifo_cnt, 4);
        tx_ready = 1'b1;
        drain();
        chk("drained_cnt", fifo_cnt, 0);

        // Reset three cycles into a MULT
        do_reset();
        push_nib(0, 2);
        push_nib(1, 3);
        drain();
        @(negedge clk);
        inst_valid = 1'b1;
        inst_data  = {OP_MULT, 2'd2, 2'd0, 2'd1};
        @(posedge clk);
        #1 inst_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        m = '{default: 0};
        txq.delete();
        rq.delete();
        retire_cnt = 0;
        #1 chk("mid_rst_retire", retire, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", inst_ready, 1);
        repeat (12) @(negedge clk);
        chk("mid_rst_no_retire", retire_cnt, 0);
        issue(OP_SEND, 2, 0, 0);
        issue(OP_SEND, 0, 0, 0);
        drain();

        // DW=16, NREG=8 instance
        do_reset();
        for (int i = 0; i < 4; i++) issue1(OP_PUSH, 0, 7, 7);
        issue1(OP_PUSH, 1, 0, 2);
        issue1(OP_MULT, 2, 0, 1);
        @(negedge clk);
        chk("w16_ovf", ovf1, 1);
        issue1(OP_SEND, 0, 0, 0);
        issue1(OP_SEND, 2, 0, 0);
        last1 = {OP_SEND, 3'd2, 3'd0, 3'd0};
        repeat (2) @(negedge clk);
        chk("w16_fifo_cnt", fifo_cnt1, 2);
        chk("w16_tx_valid", tx_valid1, 1);
        chk("w16_push_head", tx_data1, r1[0]);
        chk("w16_retire_inst", retire_inst1, last1);
        @(posedge clk);
        #1 tx_ready1 = 1'b1;
        @(posedge clk);
        #1 tx_ready1 = 1'b0;
        @(negedge clk);
        chk("w16_mult_word", tx_data1, r1[2]);
        chk("w16_fifo_cnt_pop", fifo_cnt1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
- Parametrised successor to the 4-register, 8-bit nibble calculator core.
- Accepts instructions over a valid/ready handshake and executes PUSH (nibble shift-in), ADD, MULT and SEND on an NREG x DW register file.
- MULT runs on an iterative shift-add multiplier.
- SEND results are buffered in an output FIFO that feeds the UART transmit path through a valid/ready stream.
- Adds backpressure, a sticky overflow flag and a retire pulse for LED/debug logic.

Parameters:
- DW, 8: data/register width; must exceed IMW.
- NREG, 4: register count; power of two, at least 2.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- Derived, not overridable: RW = clog2(NREG); IMW = 2*RW; IW = 2 + 3*RW.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  instruction offered.
- inst_data  in  IW  {op[1:0], ra[RW-1:0], rb[RW-1:0], rc[RW-1:0]}.
- inst_ready  out  1  core can accept an instruction.
- tx_valid  out  1  FIFO head valid.
- tx_data  out  DW  FIFO head word.
- tx_ready  in  1  consumer takes the head.
- retire  out  1  one-cycle pulse per completed instruction.
- retire_inst  out  IW  instruction that retired; held until the next retire.
- ovf  out  1  sticky arithmetic overflow.
- fifo_cnt  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync-safe release): all registers, FIFO pointers, state, retire, retire_inst and ovf go to 0; tx_valid=0; inst_ready=1 on the first cycle after release.
- Reset mid-MULT aborts the operation with no register write.
- Accept: an instruction is accepted when inst_valid && inst_ready on a rising edge.
  - inst_ready = (state==IDLE) && !fifo_full.
  - inst_ready never depends on inst_valid or inst_data.
  - While the FIFO is full, every opcode stalls.
- PUSH (00): R[ra] <= {R[ra][DW-IMW-1:0], {rb,rc}}. Written on the accept edge.
- ADD (01): R[ra] <= (R[rb] + R[rc]) mod 2^DW. Written on the accept edge. A carry-out sets ovf.
- MULT (10):
  - Operands R[rb] and R[rc] are snapshotted on the accept edge, so ra/rb/rc may alias.
  - State goes IDLE->MUL; a counter runs DW cycles, one shift-add step per cycle.
  - R[ra] receives the low DW bits on the DW-th edge after accept, then state returns to IDLE.
  - Any non-zero upper DW product bits set ovf.
  - inst_ready is 0 throughout MUL.
- SEND (11): R[ra] is pushed into the FIFO on the accept edge. Registers are unchanged.
- Retire:
  - retire pulses high for exactly one cycle, the cycle after the writing edge (accept edge, or final MUL edge).
  - retire_inst is updated in that same cycle.
- FIFO:
  - First-word fall-through: tx_valid = !empty; tx_data = head.
  - Pop on tx_valid && tx_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop on empty and push on full cannot occur and are ignored defensively.
- ovf is set only by ADD or MULT overflow and is cleared only by reset.
- States: IDLE, MUL. There is no other state; an illegal encoding recovers to IDLE.

Decomposition:
- Package calc_pkg:
  - Opcode constants OP_PUSH=2'b00, OP_ADD=2'b01, OP_MULT=2'b10, OP_SEND=2'b11.
  - State encoding ST_IDLE, ST_MUL.
  - Field-slice helper functions parameterised by RW.
- One sub-module, calc_tx_fifo: synchronous FWFT FIFO with parameters DW and FIFO_DEPTH, the same clk/rst_n, push/pop/full/empty/count ports.
- The multiplier datapath is inline.

Test Plan:
- Nibble shift-in: reset; PUSH(0,4), then PUSH(0,0) -> R0=0x40, two retire pulses.
- MULT/ADD/SEND chain, DW=8: PUSH(1,3), then MULT(2,0,1) -> R2=0xC0 written 8 edges after accept, inst_ready low for those 8 cycles. Then ADD(3,2,0) -> R3=0x00 and ovf=1. SEND 0..3 -> tx_data sequence 0x40, 0x03, 0xC0, 0x00.
- Fibonacci stream, tx_ready held 1:
  - Program: PUSH R0=0, PUSH R1=1, then repeat {ADD(2,0,1), SEND 0, copy R1->R0, R2->R1}; the copies use ADD with a zeroed register.
  - Required: tx_data carries 0, 1, 1, 2, 3, 5, 8, 13, 21, 34, with no ovf.
- Backpressure, FIFO_DEPTH=4, tx_ready=0:
  - Five SENDs -> fifo_cnt=4 after four; inst_ready drops; the fifth stalls.
  - Raise tx_ready for one cycle -> one pop, the fifth is accepted, fifo_cnt stays 4.
- Reset mid-MULT:
  - Assert rst_n=0 three cycles into MUL -> R[ra] stays 0, no retire, inst_ready=1 after release.
- Parameter sweep DW=16, NREG=8:
  - Four PUSHes of 0x3F -> R=0xFFFF (mod 2^16).
  - MULT 0xFFFF*0x0002 -> 0xFFFE, ovf=1, MUL occupancy 16 cycles.
